// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer register file.
//   state_e    : completer FSM states (IDLE, ACCESS)
//   APB_ADDR_W : APB address width
//   APB_DATA_W : APB data width
//   ADDR_LSB   : byte-address bit where the word index starts
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int ADDR_LSB   = 2;

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x 32-bit register array with asynchronous active-low clear.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset, clears every word
//   we_i     in   write enable
//   widx_i   in   write word index
//   wdata_i  in   write data
//   ridx_i   in   read word index
//   rdata_o  out  read data (combinational from ridx_i)
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer serving a DEPTH x 32-bit register file with programmable
// wait states and an error response for out-of-window or misaligned accesses.
// Ports:
//   Hclk     in   clock
//   Hresetn  in   asynchronous active-low reset
//   Pselx    in   slave select
//   Penable  in   access phase strobe
//   Pwrite   in   1 = write, 0 = read
//   Paddr    in   byte address
//   Pwdata   in   write data
//   Prdata   out  read data, valid while Pready=1 on a read
//   Pready   out  transfer completes on the edge where Penable & Pready
//   Pslverr  out  error response, valid while Pready=1
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
  localparam logic [APB_ADDR_W-1:0] WINDOW = APB_ADDR_W'(4 * DEPTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  logic [APB_ADDR_W-1:0] dec_addr;
  logic [APB_ADDR_W-1:0] dec_off;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic [APB_DATA_W-1:0] rd_data;
  logic                  we;
  logic                  load_rsp;

  // With zero wait states the response is loaded on the setup edge itself,
  // before the address has been captured, so decode the live bus address
  // while idle and the captured one during the access phase.
  assign dec_addr = (state_q == IDLE) ? Paddr : addr_q;
  assign dec_off  = dec_addr - BASE_ADDR;
  assign dec_idx  = dec_off[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign dec_err  = (dec_addr < BASE_ADDR) || (dec_off >= WINDOW) ||
                    (dec_addr[ADDR_LSB-1:0] != '0);

  apb_regfile_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (Hclk),
    .rst_ni (Hresetn),
    .we_i   (we),
    .widx_i (dec_idx),
    .wdata_i(Pwdata),
    .ridx_i (dec_idx),
    .rdata_o(rd_data)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    we        = 1'b0;
    load_rsp  = 1'b0;

    case (state_q)
      IDLE: begin
        // Penable without a preceding setup cycle is ignored here.
        if (Pselx && !Penable) begin
          addr_d   = Paddr;
          write_d  = Pwrite;
          cnt_d    = CNT_W'(WAIT_STATES);
          state_d  = ACCESS;
          pready_d = (WAIT_STATES == 0);
          load_rsp = (WAIT_STATES == 0);
        end
      end
      ACCESS: begin
        if (!Pselx) begin
          // Abort: leave without touching memory.
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (Penable) begin
          if (pready_q) begin
            // Completion edge; the error flag was settled when Pready rose.
            we        = write_q && !pslverr_q;
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
          end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - CNT_W'(1);
            pready_d = (cnt_q == CNT_W'(1));
            load_rsp = (cnt_q == CNT_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Response is loaded on the edge that raises Pready; writes keep Prdata.
    if (load_rsp) begin
      pslverr_d = dec_err;
      if (!write_d) begin
        prdata_d = dec_err ? '0 : rd_data;
      end
    end
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

  localparam int DEPTH = 16;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b1;
  logic        psel   [2];
  logic        pen    [2];
  logic        pwr    [2];
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr[2];

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(psel[0]), .Penable(pen[0]),
    .Pwrite(pwr[0]), .Paddr(paddr[0]), .Pwdata(pwdata[0]),
    .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

  apb_slave_regfile #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .WAIT_STATES(2)) dut1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(psel[1]), .Penable(pen[1]),
    .Pwrite(pwr[1]), .Paddr(paddr[1]), .Pwdata(pwdata[1]),
    .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          wcnt[2];
  logic [31:0] mem_m  [2][DEPTH];
  logic [31:0] last_rd[2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
    end
  endtask

  // Reference behaviour: word-addressed array, errors outside the window or
  // on misalignment, Prdata only follows reads.
  task automatic predict(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data);
    exp_t e;
    bit   err;
    int   idx;
    err = (addr >= 32'(4 * DEPTH)) || (addr % 4 != 0);
    idx = int'(addr / 4);
    e.d = d;
    e.err = err;
    if (wr) begin
      e.rdata = last_rd[d];
      if (!err) mem_m[d][idx] = data;
    end else begin
      e.rdata = err ? 32'h0 : mem_m[d][idx];
      last_rd[d] = e.rdata;
    end
    sbq.push_back(e);
  endtask

  task automatic bus_setup(input int d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data);
    for (int k = 0; k < 2; k++) begin
      if (k != d) begin psel[k] = 1'b0; pen[k] = 1'b0; end
    end
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = addr; pwdata[d] = data;
    @(posedge Hclk); #1;
    pen[d] = 1'b1;
  endtask

  // Leaves the bus selected after completion so a following call produces
  // a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data);
    bit done;
    predict(d, wr, addr, data);
    bus_setup(d, wr, addr, data);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Hclk);
      if (pready[d]) done = 1'b1;
      @(posedge Hclk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d addr=%h actual=no_pready required=pready", d, addr);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < 2; k++) begin psel[k] = 1'b0; pen[k] = 1'b0; end
    repeat (n) begin @(posedge Hclk); #1; end
  endtask

  // Monitor: pops an expectation whenever a DUT completes a transfer.
  always @(negedge Hclk) begin
    for (int d = 0; d < 2; d++) begin
      if (Hresetn && psel[d] && pen[d]) begin
        if (pready[d]) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty dut%0d actual=completion required=none", d);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("dut_sel", 32'(d), 32'(e.d));
            chk("pslverr", {31'h0, pslverr[d]}, {31'h0, e.err});
            chk("prdata", prdata[d], e.rdata);
            chk("wait_cycles", 32'(wcnt[d]), 32'(ws_of(d)));
          end
          wcnt[d] = 0;
        end else begin
          wcnt[d] = wcnt[d] + 1;
        end
      end else begin
        wcnt[d] = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    bit          wr;
    int          d;
    int          sel;
    bit          done;

    for (int k = 0; k < 2; k++) begin
      psel[k] = 1'b0; pen[k] = 1'b0; pwr[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
      wcnt[k] = 0;
    end
    model_clear();

    // Reset state
    #2 Hresetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_prdata", prdata[k], 32'h0);
      chk("rst_pready", {31'h0, pready[k]}, 32'h0);
      chk("rst_pslverr", {31'h0, pslverr[k]}, 32'h0);
    end
    repeat (2) @(posedge Hclk);
    #1 Hresetn = 1'b1;
    idle(1);
    xfer(0, 1'b0, 32'h0, 32'h0);
    xfer(0, 1'b0, 32'h3C, 32'h0);
    idle(1);

    // Zero wait states: write then read
    xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h8, 32'h0);
    idle(1);

    // Two wait states
    xfer(1, 1'b0, 32'h4, 32'h0);
    idle(1);

    // Out of window and misaligned writes
    xfer(0, 1'b1, 32'h40, 32'h1111_1111);
    xfer(0, 1'b1, 32'h5, 32'h2222_2222);
    xfer(0, 1'b0, 32'h0, 32'h0);
    xfer(0, 1'b0, 32'h4, 32'h0);
    xfer(0, 1'b0, 32'h40, 32'h0);
    idle(1);

    // Back-to-back write then read
    xfer(0, 1'b1, 32'hC, 32'h1234_5678);
    xfer(0, 1'b0, 32'hC, 32'h0);
    idle(1);

    // Abort during a wait state of a write
    xfer(1, 1'b1, 32'h10, 32'hAAAA_5555);
    idle(1);
    bus_setup(1, 1'b1, 32'h10, 32'h0000_0BAD);
    @(posedge Hclk); #1;
    psel[1] = 1'b0; pen[1] = 1'b0;
    @(posedge Hclk); #1;
    chk("abort_pready", {31'h0, pready[1]}, 32'h0);
    xfer(1, 1'b0, 32'h10, 32'h0);

    // Reset mid-access while an errored write presents Pready/Pslverr
    predict(1, 1'b1, 32'h44, 32'h5555_AAAA);
    bus_setup(1, 1'b1, 32'h44, 32'h5555_AAAA);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Hclk);
      if (pready[1]) done = 1'b1;
      else @(posedge Hclk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout_rst_case actual=no_pready required=pready");
    end
    #2 Hresetn = 1'b0;
    #1;
    chk("midrst_prdata", prdata[1], 32'h0);
    chk("midrst_pready", {31'h0, pready[1]}, 32'h0);
    chk("midrst_pslverr", {31'h0, pslverr[1]}, 32'h0);
    model_clear();
    psel[1] = 1'b0; pen[1] = 1'b0;
    @(posedge Hclk); #1 Hresetn = 1'b1;
    idle(1);
    xfer(1, 1'b0, 32'h10, 32'h0);
    xfer(0, 1'b0, 32'h8, 32'h0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      d   = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 9) a = 32'(4 * DEPTH + $urandom_range(0, 63) * 4);
      else              a = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'h1;
      xfer(d, wr, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(3);
    chk("sb_drain", 32'(sbq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
